// File: rtl/spi_slave_rx_tx.sv
// ---------------------------------------------------------------------------
// spi_slave_rx_tx
//
// SPI slave for the far end of the bus driven by our SPI master FSM. Every bus
// input (sclk, cs, mosi) is brought into the local clk domain through a
// synchronizer chain, so no flop is ever clocked by sclk. Received bytes leave
// on a valid/ready stream, and the byte to send back is taken from a one-entry
// TX buffer that is filled through a valid/ready handshake.
//
// Bit order is MSB first. The master drives mosi on the sclk rising edge and
// samples miso on the sclk falling edge. The slave samples mosi and moves miso
// on to the next bit when it detects the sclk falling edge.
//
// Parameters
//   DATA_W       bits per frame
//   SYNC_STAGES  flops per synchronizer on sclk, cs and mosi (must be >= 2)
//   TX_IDLE      byte shifted out when the TX buffer is empty at frame start
//
// Ports
//   clk          system clock; all logic runs on its rising edge
//   rst          asynchronous, active-high reset
//   sclk         SPI clock from the master, idles low
//   cs           SPI chip select, active low
//   mosi         master-out data
//   miso         slave-out data, always driven (0 while idle)
//   tx_data      byte to send in the next frame
//   tx_valid     tx_data valid
//   tx_ready     TX buffer empty; the buffer is written on tx_valid & tx_ready
//   rx_data      last complete received byte
//   rx_valid     rx_data valid, held until rx_ready
//   rx_ready     consumer accepts rx_data
//   busy         a frame is in progress
//   overrun      sticky: a byte completed while the previous one was unread
//   frame_err    one-cycle pulse: cs went high before a full byte arrived
//   tx_underrun  one-cycle pulse: a frame started with the TX buffer empty
// ---------------------------------------------------------------------------
module spi_slave_rx_tx #(
   parameter int                SYNC_STAGES = 2,
   parameter int                DATA_W      = 8,
   parameter logic [DATA_W-1:0] TX_IDLE     = 8'hFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs,
   input  logic              mosi,
   output logic              miso,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              busy,
   output logic              overrun,
   output logic              frame_err,
   output logic              tx_underrun
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   logic [1:0]             state;
   logic [CNT_W-1:0]       bit_cnt;
   logic [DATA_W-1:0]      tx_shift;
   logic [DATA_W-2:0]      rx_shift;
   logic [DATA_W-1:0]      tx_buf;
   logic                   tx_full;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_d;
   logic                   cs_d;

   logic                   sclk_s;
   logic                   cs_s;
   logic                   mosi_s;
   logic                   sclk_fall;
   logic                   cs_fall;
   logic                   cs_rise;
   logic                   last_bit;
   logic                   tx_wr;
   logic                   tx_load;

   // Synchronizer chains plus one history flop each for sclk and cs. mosi goes
   // through the same number of stages as sclk, so the mosi value seen in the
   // sclk_fall detection cycle is the one the master launched on the preceding
   // rising edge. Reset puts every chain in the idle bus state (sclk low,
   // cs high, mosi low), so leaving reset never looks like a bus edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sclk_d    <= sclk_sync[SYNC_STAGES-1];
         cs_d      <= cs_sync[SYNC_STAGES-1];
      end
   end

   // Edge strobes are high for exactly one clk: the first cycle in which the
   // history flop disagrees with the synchronized value. tx_load marks the
   // cycle in which a frame starts and the TX buffer is drained.
   always_comb begin
      sclk_s    = sclk_sync[SYNC_STAGES-1];
      cs_s      = cs_sync[SYNC_STAGES-1];
      mosi_s    = mosi_sync[SYNC_STAGES-1];
      sclk_fall = sclk_d & ~sclk_s;
      cs_fall   = cs_d & ~cs_s;
      cs_rise   = ~cs_d & cs_s;
      last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
      tx_wr     = tx_valid & ~tx_full;
      tx_load   = (state == ST_IDLE) & cs_fall;
   end

   // One-entry TX buffer. A frame start empties it. A write that lands in the
   // same cycle as a frame start is only possible when the buffer was already
   // empty; that frame then sends TX_IDLE and the written byte stays for the
   // next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_buf  <= '0;
         tx_full <= 1'b0;
      end else begin
         if (tx_wr) begin
            tx_buf <= tx_data;
         end
         if (tx_load) begin
            tx_full <= tx_wr;
         end else begin
            tx_full <= tx_full | tx_wr;
         end
      end
   end

   // Frame state machine together with the shift registers and the RX stream
   // handshake. While SHIFT is active, cs_rise takes priority over a
   // simultaneous sclk_fall, so a frame cut short never completes a byte by
   // accident. The last falling edge does not shift the TX register, so miso
   // keeps showing the final bit throughout HOLD. An RX accept and a new byte
   // completing in the same cycle leave rx_valid set: the later nonblocking
   // assignment wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         tx_shift    <= '0;
         rx_shift    <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         overrun     <= 1'b0;
         frame_err   <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         frame_err   <= 1'b0;
         tx_underrun <= 1'b0;

         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (cs_fall) begin
                  state    <= ST_SHIFT;
                  bit_cnt  <= '0;
                  rx_shift <= '0;
                  if (tx_full) begin
                     tx_shift <= tx_buf;
                  end else begin
                     tx_shift    <= TX_IDLE;
                     tx_underrun <= 1'b1;
                  end
               end
            end

            ST_SHIFT: begin
               if (cs_rise) begin
                  frame_err <= 1'b1;
                  state     <= ST_IDLE;
               end else if (sclk_fall) begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (last_bit) begin
                     rx_data  <= {rx_shift, mosi_s};
                     rx_valid <= 1'b1;
                     if (rx_valid && !rx_ready) begin
                        overrun <= 1'b1;
                     end
                     state <= ST_HOLD;
                  end else begin
                     rx_shift <= {rx_shift[DATA_W-3:0], mosi_s};
                     tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                  end
               end
            end

            ST_HOLD: begin
               if (cs_rise) begin
                  state <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // miso is driven straight from the TX register's MSB and forced low while
   // idle, so it moves one clk after each detected edge, just as a registered
   // output would.
   always_comb begin
      busy     = (state != ST_IDLE);
      miso     = busy & tx_shift[DATA_W-1];
      tx_ready = ~tx_full;
   end

endmodule
